// File: rtl/psum_ofifo_pkg.sv
// Shared defaults and types for the psum output FIFO.
package psum_ofifo_pkg;
    localparam int unsigned COL     = 8;
    localparam int unsigned BW_PSUM = 19;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PTR_W   = $clog2(DEPTH) + 1;

    typedef logic [BW_PSUM-1:0] psum_t;
endpackage

// File: rtl/psum_ofifo_if.sv
// Row-collection bus between the MAC array / SFU side (master) and the psum FIFO (slave).
interface psum_ofifo_if
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM
);
    logic [col*bw_psum-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [col*bw_psum-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_ovf;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_ovf
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_ovf
    );
endinterface

// File: rtl/ofifo_lane.sv
// Single-column FIFO lane: wrap-bit pointers, empty/full flags, fall-through head.
module ofifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [bw_psum-1:0] din,
    output logic [bw_psum-1:0] dout,
    output logic               empty,
    output logic               full
);
    localparam int ptr_w = $clog2(depth) + 1;

    logic [ptr_w-1:0]   wptr_q;
    logic [ptr_w-1:0]   rptr_q;
    logic [bw_psum-1:0] mem [depth];
    logic               wr_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ptr_w-1] != rptr_q[ptr_w-1]) &&
                   (wptr_q[ptr_w-2:0] == rptr_q[ptr_w-2:0]);
    // A full lane still accepts a write when the same edge frees a slot.
    assign wr_en = wr && (!full || pop);
    assign dout  = mem[rptr_q[ptr_w-2:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + ptr_w'(1);
            if (pop)   rptr_q <= rptr_q + ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[ptr_w-2:0]] <= din;
    end
endmodule

// File: rtl/psum_ofifo.sv
// Realigns skewed MAC column outputs into full rows. PSUM_OFIFO_OVF_STICKY_EN makes o_ovf sticky.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    psum_ofifo_if.slave  bus
);
    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col*bw_psum-1:0] head;
    logic                   valid;
    logic                   pop;
    logic                   ovf_evt;

    for (genvar c = 0; c < col; c++) begin : g_lane
        ofifo_lane #(
            .bw_psum (bw_psum),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (bus.wr[c]),
            .pop   (pop),
            .din   (bus.in[bw_psum*c +: bw_psum]),
            .dout  (head[bw_psum*c +: bw_psum]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

    assign valid       = ~|empty;
    assign pop         = bus.rd && valid;
    assign bus.o_valid = valid;
    assign bus.out     = valid ? head : '0;
    assign bus.o_full  = |full;
    assign bus.o_ready = ~|full;
    assign ovf_evt     = |(bus.wr & full) && !pop;

`ifdef PSUM_OFIFO_OVF_STICKY_EN
    logic       ovf_q;
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.o_ovf = ovf_q;
`else
    assign bus.o_ovf = ovf_evt;
`endif
endmodule
